// File: rtl/odo_ro_meas.sv
// Odometer ring-oscillator measurement controller: counts reference and stressed
// RO rising edges over a programmable clk window and reports both counts and their difference.
`timescale 1ns/1ps
module odo_ro_meas #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int DRAIN_CYC  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_cycles,
  input  logic             stress_en,
  input  logic             ro_ref_in,
  input  logic             ro_str_in,
  output logic             ro_ref_en,
  output logic             ro_str_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ref_count,
  output logic [CNT_W-1:0] str_count,
  output logic [CNT_W:0]   delta,
  output logic             overflow
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_DRAIN, S_DONE} state_t;

  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] DRAIN_LAST  = WIN_W'(DRAIN_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   tmr_q, tmr_d;
  logic [WIN_W-1:0]   win_q;
  logic [2:0]         ref_sync_q, str_sync_q;
  logic [CNT_W-1:0]   ref_cnt_q, str_cnt_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   ref_count_q, str_count_q;
  logic [CNT_W:0]     delta_q;
  logic               done_q;
  logic               ref_edge, str_edge, accept, counting;
  logic [CNT_W:0]     ref_inc, str_inc;

  // Returns {attempted-past-saturation, next count}; the count sticks at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) sat_inc = {1'b1, cnt};
    else      sat_inc = {1'b0, cnt + 1'b1};
  endfunction

  assign ref_edge = ref_sync_q[1] & ~ref_sync_q[2];
  assign str_edge = str_sync_q[1] & ~str_sync_q[2];
  assign accept   = (state_q == S_IDLE) && start;
  assign counting = (state_q == S_COUNT);
  assign ref_inc  = sat_inc(ref_cnt_q);
  assign str_inc  = sat_inc(str_cnt_q);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SETTLE;
        tmr_d   = '0;
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          if (win_q == '0) begin
            state_d = S_DRAIN;
            tmr_d   = '0;
          end else begin
            state_d = S_COUNT;
            tmr_d   = win_q;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (tmr_q == WIN_ONE) begin
          state_d = S_DRAIN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (tmr_q == DRAIN_LAST) state_d = S_DONE;
        else                     tmr_d   = tmr_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Enables are decoded straight from state so reset drops them without waiting for a clock.
  always_comb begin
    ro_ref_en = 1'b0;
    ro_str_en = 1'b0;
    if (!rst) begin
      if (state_q == S_SETTLE || state_q == S_COUNT) begin
        ro_ref_en = 1'b1;
        ro_str_en = 1'b1;
      end else begin
        ro_str_en = stress_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      win_q       <= '0;
      ref_sync_q  <= '0;
      str_sync_q  <= '0;
      ref_cnt_q   <= '0;
      str_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      ref_count_q <= '0;
      str_count_q <= '0;
      delta_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      ref_sync_q <= {ref_sync_q[1:0], ro_ref_in};
      str_sync_q <= {str_sync_q[1:0], ro_str_in};
      done_q     <= (state_q == S_DONE);
      if (accept) begin
        win_q     <= win_cycles;
        ref_cnt_q <= '0;
        str_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end else if (counting) begin
        if (ref_edge) ref_cnt_q <= ref_inc[CNT_W-1:0];
        if (str_edge) str_cnt_q <= str_inc[CNT_W-1:0];
        if ((ref_edge && ref_inc[CNT_W]) || (str_edge && str_inc[CNT_W])) ovf_q <= 1'b1;
      end
      if (state_q == S_DONE) begin
        ref_count_q <= ref_cnt_q;
        str_count_q <= str_cnt_q;
        delta_q     <= {1'b0, str_cnt_q} - {1'b0, ref_cnt_q};
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign ref_count = ref_count_q;
  assign str_count = str_count_q;
  assign delta     = delta_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_odo_ro_meas.sv
// Scoreboard bench for odo_ro_meas: behavioural RO models drive a default-width DUT
// and a 4-bit-counter DUT; expected result ranges are queued at start and checked on done.
`timescale 1ns/1ps
module tb_odo_ro_meas;

  typedef struct {
    int rlo; int rhi; int slo; int shi; int dlo; int dhi; int ov; int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   str_half = 21;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a, e_b;

  logic        start_a, stress_a, ro_ref_a, ro_str_a;
  logic [15:0] win_a;
  logic        ro_ref_en_a, ro_str_en_a, busy_a, done_a, overflow_a;
  logic [15:0] ref_count_a, str_count_a;
  logic [16:0] delta_a;

  logic        start_b, stress_b;
  logic        osc = 1'b0;
  logic [15:0] win_b;
  logic        ro_ref_en_b, ro_str_en_b, busy_b, done_b, overflow_b;
  logic [3:0]  ref_count_b, str_count_b;
  logic [4:0]  delta_b;

  odo_ro_meas dut_a (
    .clk(clk), .rst(rst), .start(start_a), .win_cycles(win_a), .stress_en(stress_a),
    .ro_ref_in(ro_ref_a), .ro_str_in(ro_str_a), .ro_ref_en(ro_ref_en_a), .ro_str_en(ro_str_en_a),
    .busy(busy_a), .done(done_a), .ref_count(ref_count_a), .str_count(str_count_a),
    .delta(delta_a), .overflow(overflow_a));

  odo_ro_meas #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .win_cycles(win_b), .stress_en(stress_b),
    .ro_ref_in(osc), .ro_str_in(osc), .ro_ref_en(ro_ref_en_b), .ro_str_en(ro_str_en_b),
    .busy(busy_b), .done(done_b), .ref_count(ref_count_b), .str_count(str_count_b),
    .delta(delta_b), .overflow(overflow_b));

  always #1 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always #21 osc = ~osc;

  // 21-stage ring models: idle low while disabled, toggle every half period while enabled.
  always begin
    if (ro_ref_en_a !== 1'b1) begin
      ro_ref_a = 1'b0;
      @(ro_ref_en_a);
    end else begin
      #21;
      ro_ref_a = (ro_ref_en_a === 1'b1) ? ~ro_ref_a : 1'b0;
    end
  end

  always begin
    if (ro_str_en_a !== 1'b1) begin
      ro_str_a = 1'b0;
      @(ro_str_en_a);
    end else begin
      #(str_half);
      ro_str_a = (ro_str_en_a === 1'b1) ? ~ro_str_a : 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        chk("A_unexpected_done", 1, 0, 0);
      end else begin
        e_a = exp_a.pop_front();
        chk("A_ref_count", int'(ref_count_a), e_a.rlo, e_a.rhi);
        chk("A_str_count", int'(str_count_a), e_a.slo, e_a.shi);
        chk("A_delta", int'($signed(delta_a)), e_a.dlo, e_a.dhi);
        chk("A_overflow", int'(overflow_a), e_a.ov, e_a.ov);
        chk("A_latency_cycle", cyc, e_a.cyc, e_a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && done_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        chk("B_unexpected_done", 1, 0, 0);
      end else begin
        e_b = exp_b.pop_front();
        chk("B_ref_count", int'(ref_count_b), e_b.rlo, e_b.rhi);
        chk("B_str_count", int'(str_count_b), e_b.slo, e_b.shi);
        chk("B_delta", int'($signed(delta_b)), e_b.dlo, e_b.dhi);
        chk("B_overflow", int'(overflow_b), e_b.ov, e_b.ov);
        chk("B_latency_cycle", cyc, e_b.cyc, e_b.cyc);
      end
    end
  end

  task automatic run_a(input int win, input bit push, input int rlo, input int rhi,
                       input int slo, input int shi, input int dlo, input int dhi, input int ov);
    exp_t e;
    @(negedge clk);
    win_a   = 16'(win);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    e = '{rlo, rhi, slo, shi, dlo, dhi, ov, cyc + 12 + win};
    if (push) exp_a.push_back(e);
  endtask

  task automatic run_b(input int win, input int rlo, input int rhi,
                       input int slo, input int shi, input int dlo, input int dhi, input int ov);
    exp_t e;
    @(negedge clk);
    win_b   = 16'(win);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    e = '{rlo, rhi, slo, shi, dlo, dhi, ov, cyc + 12 + win};
    exp_b.push_back(e);
  endtask

  task automatic wait_a(input int budget);
    int n = 0;
    while (exp_a.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_a.size() != 0) begin
      chk("A_done_timeout", 1, 0, 0);
      exp_a.delete();
    end
  endtask

  task automatic wait_b(input int budget);
    int n = 0;
    while (exp_b.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_b.size() != 0) begin
      chk("B_done_timeout", 1, 0, 0);
      exp_b.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; stress_a = 1'b0; win_a = '0;
    start_b = 1'b0; stress_b = 1'b0; win_b = '0;
    repeat (4) @(negedge clk);
    chk("A_reset_outputs", int'({ro_ref_en_a, ro_str_en_a, busy_a, done_a, ref_count_a,
                                 str_count_a, delta_a, overflow_a} != '0), 0, 0);
    chk("B_reset_outputs", int'({ro_ref_en_b, ro_str_en_b, busy_b, done_b, ref_count_b,
                                 str_count_b, delta_b, overflow_b} != '0), 0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Matched ROs, 840 ns window.
    run_a(420, 1'b1, 19, 21, 19, 21, -1, 1, 0);
    chk("A_busy_after_start", int'(busy_a), 1, 1);
    wait_a(600);

    // Slow stressed RO (50 ns) against 42 ns reference, 2000 ns window.
    str_half = 25;
    run_a(1000, 1'b1, 46, 48, 39, 41, -9, -5, 0);
    wait_a(1200);
    str_half = 21;

    // Zero window.
    run_a(0, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    wait_a(50);

    // Second start mid-COUNT must be ignored.
    run_a(420, 1'b1, 19, 21, 19, 21, -1, 1, 0);
    repeat (150) @(negedge clk);
    win_a   = 16'd5;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_a(600);
    repeat (30) @(negedge clk);

    // Stress hold in IDLE and through a measurement.
    stress_a = 1'b1;
    @(negedge clk);
    chk("A_idle_stress_str_en", int'(ro_str_en_a), 1, 1);
    chk("A_idle_stress_ref_en", int'(ro_ref_en_a), 0, 0);
    run_a(100, 1'b1, 4, 5, 4, 5, -1, 1, 0);
    repeat (50) @(negedge clk);
    chk("A_count_str_en", int'(ro_str_en_a), 1, 1);
    chk("A_count_ref_en", int'(ro_ref_en_a), 1, 1);
    wait_a(200);
    chk("A_post_stress_str_en", int'(ro_str_en_a), 1, 1);
    chk("A_post_stress_ref_en", int'(ro_ref_en_a), 0, 0);
    stress_a = 1'b0;
    @(negedge clk);

    // Reset during COUNT: everything drops at once, no done pulse.
    run_a(420, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #0.2;
    chk("A_midcount_reset_outputs", int'({ro_ref_en_a, ro_str_en_a, busy_a, done_a, ref_count_a,
                                          str_count_a, delta_a, overflow_a} != '0), 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_a(420, 1'b1, 19, 21, 19, 21, -1, 1, 0);
    wait_a(600);

    // 4-bit counters saturate; the next start clears overflow.
    run_b(2000, 15, 15, 15, 15, 0, 0, 1);
    wait_b(2200);
    @(negedge clk);
    chk("B_overflow_held", int'(overflow_b), 1, 1);
    run_b(0, 0, 0, 0, 0, 0, 0, 0);
    chk("B_overflow_cleared_on_start", int'(overflow_b), 0, 0);
    wait_b(50);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
